// File: rtl/cordic_seq_pkg.sv
// Shared definitions for the sequential rotation-mode CORDIC engine:
// default sizes, FSM encodings and the master arctangent table.
package cordic_seq_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_ITER  = 16;

  // Master arctangent table precision: 1.0 rad = 2^30
  localparam int ATAN_TABLE_FRAC = 30;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_X_OP = 3'd1;
  localparam logic [2:0] ST_Y_OP = 3'd2;
  localparam logic [2:0] ST_Z_OP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Angle fraction bits for a given magnitude width (1.0 rad = 2^(width-2))
  function automatic int angle_frac(input int width);
    return width - 2;
  endfunction

  // Width of the iteration counter; at least one bit even for a single pass
  function automatic int idx_width(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

  // floor(atan(2^-idx) * 2^30); past idx 15 the series term x^3/3 is below
  // one LSB so the entry is simply 2^(30-idx) - 1
  function automatic logic [31:0] atan_q30(input int idx);
    logic [31:0] v;
    case (idx)
      0:  v = 32'h3243_F6A8;
      1:  v = 32'h1DAC_6705;
      2:  v = 32'h0FAD_BAFC;
      3:  v = 32'h07F5_6EA6;
      4:  v = 32'h03FE_AB76;
      5:  v = 32'h01FF_D55B;
      6:  v = 32'h00FF_FAAA;
      7:  v = 32'h007F_FF55;
      8:  v = 32'h003F_FFEA;
      9:  v = 32'h001F_FFFD;
      10: v = 32'h000F_FFFF;
      11: v = 32'h0007_FFFF;
      12: v = 32'h0003_FFFF;
      13: v = 32'h0001_FFFF;
      14: v = 32'h0000_FFFF;
      15: v = 32'h0000_7FFF;
      default: v = (idx < 30) ? ((32'd1 << (30 - idx)) - 32'd1) : 32'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: index i -> round(atan(2^-i) * 2^(WIDTH-2)).
// The 2^30 master table is rescaled with round-half-up to the angle format.
module cordic_atan_rom
  import cordic_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] angle
);

  localparam int FRAC = angle_frac(WIDTH);

  logic [63:0] q30;

  // Widen the selected master entry so rounding cannot overflow
  always_comb begin
    q30 = {32'd0, atan_q30(int'(idx))};
  end

  generate
    if (FRAC < ATAN_TABLE_FRAC) begin : g_round_down
      localparam int SH = ATAN_TABLE_FRAC - FRAC;
      localparam logic [63:0] HALF = 64'd1 << (SH - 1);
      assign angle = WIDTH'((q30 + HALF) >> SH);
    end else begin : g_scale_up
      assign angle = WIDTH'(q30 << (FRAC - ATAN_TABLE_FRAC));
    end
  endgenerate

endmodule

// File: rtl/cordic_seq.sv
// Iterative rotation-mode CORDIC sequencer. One external sign-magnitude
// adder is shared over three cycles per iteration (X, then Y, then Z).
// The new X is parked in a shadow register until Z_OP so that the Y update
// still sees the old X.
module cordic_seq
  import cordic_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ITER  = DEFAULT_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  input  logic             x_in_s,
  input  logic             y_in_s,
  input  logic             z_in_s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic             x_out_s,
  output logic             y_out_s,
  output logic             z_out_s,
  output logic [WIDTH-1:0] add_a,
  output logic             add_asign,
  output logic [WIDTH-1:0] add_b,
  output logic             add_as,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_sign
);

  localparam int IW = idx_width(ITER);
  localparam logic [IW-1:0] LAST_I = IW'(ITER - 1);

  logic [2:0]       state;
  logic [IW-1:0]    i;
  logic [WIDTH-1:0] x, y, z, xn;
  logic             xs, ys, zs, xns;
  logic             d;
  logic [WIDTH-1:0] atan_i;
  logic             res_sign;

  cordic_atan_rom #(
    .WIDTH(WIDTH),
    .IDX_W(IW)
  ) u_atan_rom (
    .idx  (i),
    .angle(atan_i)
  );

  // A zero magnitude from the adder is always stored as +0
  assign res_sign = add_sign & (|add_s);

  assign busy = (state == ST_X_OP) || (state == ST_Y_OP) || (state == ST_Z_OP);
  assign done = (state == ST_DONE);

  assign x_out   = x;
  assign y_out   = y;
  assign z_out   = z;
  assign x_out_s = xs;
  assign y_out_s = ys;
  assign z_out_s = zs;

  // Steer the shared adder; d = 1 is a positive rotation, sign bit 1 is
  // negative, so "same direction" is d XOR sign and the op bits follow
  // x - d*y, y + d*x and z - d*atan. Idle states park the adder at zero.
  always_comb begin
    add_a     = '0;
    add_asign = 1'b0;
    add_b     = '0;
    add_as    = 1'b0;
    case (state)
      ST_X_OP: begin
        add_a     = x;
        add_asign = xs;
        add_b     = y >> i;
        add_as    = d ^ ys;
      end
      ST_Y_OP: begin
        add_a     = y;
        add_asign = ys;
        add_b     = x >> i;
        add_as    = ~(d ^ xs);
      end
      ST_Z_OP: begin
        add_a     = z;
        add_asign = zs;
        add_b     = atan_i;
        add_as    = d;
      end
      default: ;
    endcase
  end

  // Sequencer and working registers; reset aborts any run without a done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      i     <= '0;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      xn    <= '0;
      xs    <= 1'b0;
      ys    <= 1'b0;
      zs    <= 1'b0;
      xns   <= 1'b0;
      d     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x     <= x_in;
            y     <= y_in;
            z     <= z_in;
            xs    <= x_in_s & (|x_in);
            ys    <= y_in_s & (|y_in);
            zs    <= z_in_s & (|z_in);
            d     <= ~(z_in_s & (|z_in));
            i     <= '0;
            state <= ST_X_OP;
          end
        end
        ST_X_OP: begin
          xn    <= add_s;
          xns   <= res_sign;
          state <= ST_Y_OP;
        end
        ST_Y_OP: begin
          y     <= add_s;
          ys    <= res_sign;
          state <= ST_Z_OP;
        end
        ST_Z_OP: begin
          z  <= add_s;
          zs <= res_sign;
          x  <= xn;
          xs <= xns;
          d  <= ~res_sign;
          if (i == LAST_I) begin
            state <= ST_DONE;
          end else begin
            i     <= i + IW'(1);
            state <= ST_X_OP;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
